// File: rtl/uop_queue_pkg.sv
// Shared types for the rename-to-dispatch micro-op queue.
// uop_t is stored opaquely; the queue never looks inside it.
package uop_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] op;
  } uop_t;

  localparam int UOP_WIDTH  = $bits(uop_t);
  localparam int UOPQ_DEPTH = 8;

  typedef logic [$clog2(UOPQ_DEPTH+1)-1:0] uopq_cnt_t;

endpackage

// File: rtl/uop_queue_lead_ones_cnt.sv
// Counts the run of consecutive ones starting at bit 0.
// Used to turn lane-valid vectors into in-order transfer counts.
module lead_ones_cnt
  import uop_queue_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0]               vec,
  output logic [$clog2(W+1)-1:0]     cnt
);

  localparam int CW = $clog2(W+1);

  logic run;

  // Walk up from lane 0 and stop counting at the first zero
  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (run && vec[i]) cnt = CW'(i + 1);
      else               run = 1'b0;
    end
  end

endmodule

// File: rtl/uop_queue.sv
// Multi-lane in-order micro-op queue between rename and dispatch.
// Optional feature macro: QU_UOP_QUEUE_BYPASS_EN (empty-queue enq->deq bypass).
module uop_queue
  import uop_queue_pkg::*;
#(
  parameter int DEPTH     = UOPQ_DEPTH,
  parameter int ENQ_WIDTH = 2,
  parameter int DEQ_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [ENQ_WIDTH-1:0]          enq_valid,
  input  uop_t [ENQ_WIDTH-1:0]          enq_uop,
  output logic                          enq_ready,
  output logic [DEQ_WIDTH-1:0]          deq_valid,
  output uop_t [DEQ_WIDTH-1:0]          deq_uop,
  input  logic [DEQ_WIDTH-1:0]          deq_ready,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          empty,
  output logic                          full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = $clog2(ENQ_WIDTH+1);
  localparam int DW = $clog2(DEQ_WIDTH+1);

  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  uop_t                 mem [DEPTH];

  logic [EW-1:0]        n_enq_raw;
  logic [EW-1:0]        n_enq;
  logic [DW-1:0]        n_deq_raw;
  logic [DW-1:0]        n_deq;
  logic [DW-1:0]        skip;   // enqueue lanes consumed directly by the bypass
  logic [DW-1:0]        n_pop;  // entries removed from storage
  logic [DEQ_WIDTH-1:0] deq_hs;
  logic                 byp;
  logic [ENQ_WIDTH-1:0] enq_vld_inc;

  // Space check uses only the registered count, so same-cycle pops never free room
  assign enq_ready = (DEPTH - int'(count)) >= ENQ_WIDTH;
  assign empty     = (count == '0);
  assign full      = (int'(count) == DEPTH);

  lead_ones_cnt #(.W(ENQ_WIDTH)) u_enq_cnt (
    .vec (enq_valid),
    .cnt (n_enq_raw)
  );

  assign deq_hs = deq_valid & deq_ready;

  lead_ones_cnt #(.W(DEQ_WIDTH)) u_deq_cnt (
    .vec (deq_hs),
    .cnt (n_deq_raw)
  );

  assign n_enq = (enq_ready && !flush) ? n_enq_raw : '0;
  assign n_deq = flush ? '0 : n_deq_raw;
  assign skip  = byp ? n_deq : '0;
  assign n_pop = byp ? '0 : n_deq;

`ifdef QU_UOP_QUEUE_BYPASS_EN
  localparam int LW = (ENQ_WIDTH > DEQ_WIDTH) ? ENQ_WIDTH : DEQ_WIDTH;

  logic [LW-1:0] enq_vld_ext;
  uop_t [LW-1:0] enq_uop_ext;

  // Widen the enqueue lanes so every dequeue lane has a bypass source
  always_comb begin
    enq_vld_ext = '0;
    enq_uop_ext = '0;
    for (int j = 0; j < ENQ_WIDTH; j++) begin
      enq_vld_ext[j] = enq_valid[j];
      enq_uop_ext[j] = enq_uop[j];
    end
  end

  assign byp = (count == '0) && !flush;
`else
  assign byp = 1'b0;
`endif

  // Present the oldest entries (or bypassed enqueue lanes) to dispatch
  always_comb begin
    deq_valid = '0;
    deq_uop   = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      if (int'(count) > i) begin
        deq_valid[i] = 1'b1;
        deq_uop[i]   = mem[head + PW'(i)];
      end
    end
`ifdef QU_UOP_QUEUE_BYPASS_EN
    if (byp) begin
      for (int i = 0; i < DEQ_WIDTH; i++) begin
        if (enq_vld_ext[i] && enq_ready) begin
          deq_valid[i] = 1'b1;
          deq_uop[i]   = enq_uop_ext[i];
        end
      end
    end
`endif
  end

  // Write accepted lanes that were not already handed straight to dispatch
  always_ff @(posedge clk) begin
    for (int j = 0; j < ENQ_WIDTH; j++) begin
      if (j < int'(n_enq) && j >= int'(skip))
        mem[tail + PW'(j - int'(skip))] <= enq_uop[j];
    end
  end

  // Pointer and occupancy update; flush wins over any transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(n_pop);
      tail  <= tail + PW'(int'(n_enq) - int'(skip));
      count <= count + CW'(n_enq) - CW'(n_deq);
    end
  end

  // Enqueue lanes must form a contiguous prefix from lane 0
  assign enq_vld_inc = enq_valid + ENQ_WIDTH'(1);

  a_enq_contig: assert property (@(posedge clk) disable iff (rst)
    (enq_valid & enq_vld_inc) == '0);

endmodule
